// File: rtl/micro_sequencer.sv
// Next-microaddress generator: registers the control-memory address and decodes addr_ctrl.
// Optional build macro OVF_TRAP_EN enables the ALU-overflow trap to OVF_ADDR.
module micro_sequencer #(
    parameter int AW       = 5,
    parameter int IF_ADDR  = 0,
    parameter int HC_EXIT  = 13,
    parameter int OVF_ADDR = 30,
    parameter int ILL_ADDR = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic [2:0]    addr_ctrl,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [4:0]    sh_cnt,
    input  logic          overflow,
    output logic [AW-1:0] uaddr,
    output logic          hc_active,
    output logic          dispatch_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } hc_state_e;

    localparam logic [AW-1:0] A_IF  = AW'(IF_ADDR);
    localparam logic [AW-1:0] A_HC  = AW'(HC_EXIT);
    localparam logic [AW-1:0] A_ILL = AW'(ILL_ADDR);

    hc_state_e     state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [AW-1:0] uaddr_q, uaddr_d;
    logic          err_q, err_d;
    logic [AW-1:0] dt1_addr, dt2_addr, dt3_addr;
    logic          dt1_ok, dt2_ok, dt3_ok;

    always_comb begin
        dt1_addr = A_ILL;
        dt1_ok   = 1'b1;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20:   dt1_addr = AW'(12);
                6'h00:   dt1_addr = AW'(14);
                6'h04:   dt1_addr = AW'(15);
                6'h1A:   dt1_addr = AW'(16);
                6'h18:   dt1_addr = AW'(18);
                6'h10:   dt1_addr = AW'(2);
                6'h11:   dt1_addr = AW'(3);
                6'h12:   dt1_addr = AW'(4);
                6'h13:   dt1_addr = AW'(5);
                6'h08:   dt1_addr = AW'(10);
                6'h09:   dt1_addr = AW'(11);
                default: dt1_ok   = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h04:               dt1_addr = AW'(7);
                6'h02:               dt1_addr = AW'(8);
                6'h03:               dt1_addr = AW'(9);
                6'h0F:               dt1_addr = AW'(6);
                6'h08, 6'h23, 6'h2B: dt1_addr = AW'(19);
                6'h0D:               dt1_addr = AW'(20);
                6'h1C: begin
                    if (funct == 6'h00 || funct == 6'h04) dt1_addr = AW'(18);
                    else                                  dt1_ok   = 1'b0;
                end
                default:             dt1_ok   = 1'b0;
            endcase
        end
    end

    always_comb begin
        dt2_addr = A_ILL;
        dt2_ok   = 1'b1;
        if (opcode == 6'h1C && funct == 6'h00)      dt2_addr = AW'(22);
        else if (opcode == 6'h1C && funct == 6'h04) dt2_addr = AW'(23);
        else if (opcode == 6'h00 && funct == 6'h18) dt2_addr = A_IF;
        else                                        dt2_ok   = 1'b0;

        dt3_addr = A_ILL;
        dt3_ok   = 1'b1;
        case (opcode)
            6'h23:   dt3_addr = AW'(24);
            6'h2B:   dt3_addr = AW'(26);
            6'h08:   dt3_addr = A_HC;
            default: dt3_ok   = 1'b0;
        endcase
    end

`ifdef OVF_TRAP_EN
    logic ovf_trap;
    assign ovf_trap = overflow && (uaddr_q inside {[AW'(2):AW'(12)], AW'(14), AW'(15),
                                                   AW'(16), AW'(18), AW'(19), AW'(20)});
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        uaddr_d = uaddr_q;
        err_d   = 1'b0;
        if (!stall) begin
            if (state_q == ST_COUNT) begin
                // addr_ctrl is ignored while counting: the held word is the HC word itself
                if (cnt_q == 5'd1) begin
                    uaddr_d = A_HC;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end else begin
                case (addr_ctrl)
                    3'b000: uaddr_d = A_IF;
                    3'b001: uaddr_d = uaddr_q + 1'b1;
                    3'b010: begin uaddr_d = dt1_addr; err_d = !dt1_ok; end
                    3'b011: begin uaddr_d = dt2_addr; err_d = !dt2_ok; end
                    3'b100: begin uaddr_d = dt3_addr; err_d = !dt3_ok; end
                    3'b101: begin
                        if (sh_cnt <= 5'd1) begin
                            uaddr_d = A_HC;
                        end else begin
                            cnt_d   = sh_cnt - 5'd1;
                            state_d = ST_COUNT;
                        end
                    end
                    default: begin uaddr_d = A_IF; err_d = 1'b1; end
                endcase
            end
`ifdef OVF_TRAP_EN
            if (ovf_trap) begin
                uaddr_d = AW'(OVF_ADDR);
                state_d = ST_IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            uaddr_q <= A_IF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uaddr_q <= uaddr_d;
            err_q   <= err_d;
        end
    end

    assign uaddr        = uaddr_q;
    assign hc_active    = (state_q == ST_COUNT);
    assign dispatch_err = err_q && !stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer; expected values are hand-derived.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] addr_ctrl = 3'b000;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic [4:0] sh_cnt = 5'd0;
    logic       overflow = 1'b0;
    logic [4:0] uaddr;
    logic       hc_active;
    logic       dispatch_err;

    int n_checks = 0;
    int n_fail = 0;

    micro_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .addr_ctrl(addr_ctrl),
        .opcode(opcode), .funct(funct), .sh_cnt(sh_cnt), .overflow(overflow),
        .uaddr(uaddr), .hc_active(hc_active), .dispatch_err(dispatch_err)
    );

    always #5 clk = ~clk;

    // Dispatch vectors: addr_ctrl, opcode, funct, expected next uaddr (31 = illegal)
    localparam int NV = 31;
    int v_ac [NV] = '{2,2,2,2,2,2,2,2,2,2,2, 2,2,2,2,2,2,2,2,2,2, 2,2,
                      3,3,3,3, 4,4,4,4};
    int v_op [NV] = '{'h00,'h00,'h00,'h00,'h00,'h00,'h00,'h00,'h00,'h00,'h00,
                      'h04,'h02,'h03,'h0F,'h08,'h23,'h2B,'h0D,'h1C,'h1C,
                      'h3F,'h1C,
                      'h1C,'h1C,'h00,'h00,
                      'h23,'h2B,'h08,'h04};
    int v_fn [NV] = '{'h20,'h00,'h04,'h1A,'h18,'h10,'h11,'h12,'h13,'h08,'h09,
                      0,0,0,0,0,0,0,0,'h00,'h04,
                      0,'h01,
                      'h00,'h04,'h18,'h20,
                      0,0,0,0};
    int v_ex [NV] = '{12,14,15,16,18,2,3,4,5,10,11,
                      7,8,9,6,19,19,19,20,18,18,
                      31,31,
                      22,23,0,31,
                      24,26,13,31};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_addr14();
        addr_ctrl = 3'b000; tick();
        addr_ctrl = 3'b010; opcode = 6'h00; funct = 6'h00; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (uaddr !== 5'd0 || hc_active !== 1'b0 || dispatch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: uaddr=%0d hc=%b err=%b, expected 0 0 0", uaddr, hc_active, dispatch_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_dispatch();
        int exp [2] = '{1, 12};
        addr_ctrl = 3'b001; tick();
        n_checks++;
        if (uaddr !== 5'(exp[0])) begin
            n_fail++; $display("FAIL seq: uaddr=%0d expected %0d", uaddr, exp[0]);
        end
        addr_ctrl = 3'b010; opcode = 6'h00; funct = 6'h20; tick();
        n_checks++;
        if (uaddr !== 5'(exp[1]) || dispatch_err !== 1'b0) begin
            n_fail++; $display("FAIL dt1_add: uaddr=%0d err=%b expected %0d 0", uaddr, dispatch_err, exp[1]);
        end
    endtask

    task automatic test_hold_count();
        int cnts [3] = '{4, 0, 1};
        for (int t = 0; t < 3; t++) begin
            int cycles;
            goto_addr14();
            addr_ctrl = 3'b101; sh_cnt = 5'(cnts[t]);
            cycles = (cnts[t] < 1) ? 1 : cnts[t];
            for (int c = 1; c <= cycles; c++) begin
                tick();
                sh_cnt = 5'd31;
                n_checks++;
                if (c < cycles) begin
                    if (uaddr !== 5'd14 || hc_active !== 1'b1) begin
                        n_fail++;
                        $display("FAIL hc_hold sh=%0d c=%0d: uaddr=%0d hc=%b expected 14 1", cnts[t], c, uaddr, hc_active);
                    end
                end else if (uaddr !== 5'd13 || hc_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hc_exit sh=%0d: uaddr=%0d hc=%b expected 13 0", cnts[t], uaddr, hc_active);
                end
            end
        end
    endtask

    task automatic test_illegal();
        addr_ctrl = 3'b010; opcode = 6'h3F; funct = 6'h00; tick();
        n_checks++;
        if (uaddr !== 5'd31 || dispatch_err !== 1'b1) begin
            n_fail++; $display("FAIL ill_op: uaddr=%0d err=%b expected 31 1", uaddr, dispatch_err);
        end
        addr_ctrl = 3'b001; tick();
        n_checks++;
        if (uaddr !== 5'd0 || dispatch_err !== 1'b0) begin
            n_fail++; $display("FAIL seq_wrap: uaddr=%0d err=%b expected 0 0", uaddr, dispatch_err);
        end
        for (int k = 0; k < 2; k++) begin
            addr_ctrl = 3'b001; tick();
            addr_ctrl = (k == 0) ? 3'b111 : 3'b110; tick();
            n_checks++;
            if (uaddr !== 5'd0 || dispatch_err !== 1'b1) begin
                n_fail++; $display("FAIL ac_ill k=%0d: uaddr=%0d err=%b expected 0 1", k, uaddr, dispatch_err);
            end
            addr_ctrl = 3'b000; tick();
            n_checks++;
            if (dispatch_err !== 1'b0) begin
                n_fail++; $display("FAIL err_pulse k=%0d: err=%b expected 0", k, dispatch_err);
            end
        end
    endtask

    task automatic test_dispatch_tables();
        for (int i = 0; i < NV; i++) begin
            addr_ctrl = 3'b000; tick();
            addr_ctrl = 3'(v_ac[i]); opcode = 6'(v_op[i]); funct = 6'(v_fn[i]); tick();
            n_checks++;
            if (uaddr !== 5'(v_ex[i]) || dispatch_err !== (v_ex[i] == 31)) begin
                n_fail++;
                $display("FAIL dispatch[%0d] ac=%0d op=%h fn=%h: uaddr=%0d err=%b expected %0d %b",
                         i, v_ac[i], v_op[i], v_fn[i], uaddr, dispatch_err, v_ex[i], v_ex[i] == 31);
            end
        end
    endtask

    task automatic test_flows();
        int lw_ac [6] = '{0, 1, 2, 4, 1, 0};
        int lw_ex [6] = '{0, 1, 19, 24, 25, 0};
        int md_ac [3] = '{1, 2, 3};
        int md_ex [3] = '{1, 18, 22};
        opcode = 6'h23; funct = 6'h00;
        for (int i = 0; i < 6; i++) begin
            addr_ctrl = 3'(lw_ac[i]); tick();
            n_checks++;
            if (uaddr !== 5'(lw_ex[i])) begin
                n_fail++; $display("FAIL flow_lw step %0d: uaddr=%0d expected %0d", i, uaddr, lw_ex[i]);
            end
        end
        opcode = 6'h1C; funct = 6'h00;
        for (int i = 0; i < 3; i++) begin
            addr_ctrl = 3'(md_ac[i]); tick();
            n_checks++;
            if (uaddr !== 5'(md_ex[i])) begin
                n_fail++; $display("FAIL flow_madd step %0d: uaddr=%0d expected %0d", i, uaddr, md_ex[i]);
            end
        end
    endtask

    task automatic test_stall();
        goto_addr14();
        addr_ctrl = 3'b101; sh_cnt = 5'd5;
        tick(); tick(); tick();
        stall = 1'b1; addr_ctrl = 3'b111;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++;
            if (uaddr !== 5'd14 || hc_active !== 1'b1 || dispatch_err !== 1'b0) begin
                n_fail++; $display("FAIL stall %0d: uaddr=%0d hc=%b err=%b expected 14 1 0", s, uaddr, hc_active, dispatch_err);
            end
        end
        stall = 1'b0; addr_ctrl = 3'b101;
        tick();
        n_checks++;
        if (uaddr !== 5'd14 || hc_active !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume: uaddr=%0d hc=%b expected 14 1", uaddr, hc_active);
        end
        tick();
        n_checks++;
        if (uaddr !== 5'd13 || hc_active !== 1'b0) begin
            n_fail++; $display("FAIL stall_exit: uaddr=%0d hc=%b expected 13 0", uaddr, hc_active);
        end
    endtask

    task automatic test_reset_mid_hold();
        goto_addr14();
        addr_ctrl = 3'b101; sh_cnt = 5'd8;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (uaddr !== 5'd0 || hc_active !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: uaddr=%0d hc=%b expected 0 0", uaddr, hc_active);
        end
        #1 rst_n = 1'b1;
        addr_ctrl = 3'b001; tick();
        n_checks++;
        if (uaddr !== 5'd1 || hc_active !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: uaddr=%0d hc=%b expected 1 0", uaddr, hc_active);
        end
    endtask

    task automatic test_overflow();
        int e12, e13, e_hc;
        logic e_hca;
`ifdef OVF_TRAP_EN
        e12 = 30; e13 = 14; e_hc = 30; e_hca = 1'b0;
`else
        e12 = 13; e13 = 14; e_hc = 14; e_hca = 1'b1;
`endif
        addr_ctrl = 3'b000; tick();
        addr_ctrl = 3'b010; opcode = 6'h00; funct = 6'h20; tick();
        addr_ctrl = 3'b001; overflow = 1'b1; tick();
        overflow = 1'b0;
        n_checks++;
        if (uaddr !== 5'(e12)) begin
            n_fail++; $display("FAIL ovf_at12: uaddr=%0d expected %0d", uaddr, e12);
        end
        addr_ctrl = 3'b000; tick();
        addr_ctrl = 3'b010; opcode = 6'h08; funct = 6'h00; tick();
        addr_ctrl = 3'b100; tick();
        addr_ctrl = 3'b001; overflow = 1'b1; tick();
        overflow = 1'b0;
        n_checks++;
        if (uaddr !== 5'(e13)) begin
            n_fail++; $display("FAIL ovf_at13: uaddr=%0d expected %0d", uaddr, e13);
        end
        addr_ctrl = 3'b101; sh_cnt = 5'd6; tick();
        overflow = 1'b1; tick();
        overflow = 1'b0;
        n_checks++;
        if (uaddr !== 5'(e_hc) || hc_active !== e_hca) begin
            n_fail++; $display("FAIL ovf_hc_abort: uaddr=%0d hc=%b expected %0d %b", uaddr, hc_active, e_hc, e_hca);
        end
        rst_n = 1'b0; #2 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_seq_dispatch();
        test_hold_count();
        test_illegal();
        test_dispatch_tables();
        test_flows();
        test_stall();
        test_reset_mid_hold();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
